cmem_access_arbiter: RTL
========================

// Module: cmem_access_arbiter
// PURPOSE
//  Shares one single-ported cmem register-file port between two requesters: Amiga clockport (cp) and Pi SPI (spi).
//  Each side issues single-cycle access pulses. These are captured in a 1-deep buffer per side and serialised onto the port.
//  mem_side tells the cmem which side's semantics apply (read-clear/OR-set event regs). Sits between the bus front-ends and cmem.
// PARAMETERS
//  RD_LAT      1  cycles from mem_read strobe to valid mem_rdata (1..3)
//  STARVE_MAX  4  consecutive cp grants allowed while spi is pending before spi is forced (1..15)
// PORTS
//  clk200        in   1  system clock
//  reset         in   1  synchronous reset, active-high
//  cp_req        in   1  access request pulse; cp_we/cp_addr/cp_wdata sampled the same cycle
//  cp_we         in   1  1=write, 0=read
//  cp_addr       in   4  cmem register address
//  cp_wdata      in   4  write data
//  cp_busy       out  1  cp buffer holds an unserviced request
//  cp_done       out  1  1-cycle completion pulse
//  cp_rdata      out  4  read data, valid with cp_done (held until next cp read done)
//  cp_overrun    out  1  sticky: cp_req dropped because buffer full
//  spi_*         --      identical set for the SPI side (spi_req .. spi_overrun)
//  mem_read      out  1  port read strobe, 1 cycle
//  mem_write     out  1  port write strobe, 1 cycle
//  mem_address   out  4  port address
//  mem_wdata     out  4  port write data
//  mem_side      out  1  0=cp, 1=spi; valid while a strobe is high
//  mem_rdata     in   4  port read data, RD_LAT cycles after mem_read
// BEHAVIOUR
//  Reset: all outputs 0, buffers empty, FSM IDLE, starve count 0. A reset mid-access aborts it: no done pulse, pending requests lost.
//  Capture:
//   - req with buffer empty, or buffer freed this same cycle, is stored and busy=1 next cycle.
//   - req with buffer full and not freed is dropped and sets overrun.
//  Buffer frees in the cycle its ISSUE strobe is asserted.
//  FSM IDLE/ISSUE/WAIT:
//   - IDLE with any buffer valid: pick winner, register strobe -> ISSUE next cycle.
//   - ISSUE: exactly one of mem_read/mem_write high; address/wdata/side from winner.
//   - ISSUE write -> IDLE; done pulse in the cycle after ISSUE.
//   - ISSUE read -> WAIT for RD_LAT cycles. mem_rdata is sampled in the last WAIT cycle. done+rdata follow the next cycle, FSM in IDLE that cycle.
//   - FSM can re-grant in the same cycle done is pulsed.
//  Latency: req in cycle 0 -> strobe in cycle 2. Write done in cycle 3. Read done in cycle 3+RD_LAT.
//  Arbitration: cp has priority.
//   - Starve counter increments per cp grant while spi is valid, saturating at STARVE_MAX.
//   - Counter clears on any spi grant, or when spi is not valid.
//   - counter==STARVE_MAX with spi valid -> spi wins.
//  Simultaneous: cp_req and spi_req in the same cycle with both buffers empty -> cp served first, spi next.
//  Never two strobes in one cycle. mem_read and mem_write are mutually exclusive.
//  Done pulses of both sides never coincide.
//  Address/data are passed unmodified. Arbiter holds no knowledge of register side effects.
// STRUCTURE
//  Package cmem_pkg:
//   - FSM state enum (IDLE, ISSUE, WAIT)
//   - SIDE_CP=0, SIDE_SPI=1
//   - register address constants (REG_VERSION=10, REG_CONFIG=11, REG_R_EVENTS=12, REG_R_ENABLE=13, REG_A_EVENTS=14, REG_A_ENABLE=15)
//  Sub-module cmem_req_buf:
//   - 1-deep capture of {we,addr,wdata} with valid, free and overrun
//   - instantiated once per side
//  Top holds FSM, starve counter, WAIT counter, rdata/done registers.
// TESTING
//  1. Reset, cp write addr 11 data 4'h2 -> mem_write=1 in cycle 2, side=0, addr=11, wdata=2; cp_done in cycle 3.
//  2. spi read addr 12 with model returning 4'h5, RD_LAT=2 -> mem_read in cycle 2, spi_done+spi_rdata=5 in cycle 5.
//  3. cp_req and spi_req same cycle (both writes) -> cp strobe cycle 2, spi strobe cycle 3, done pulses cycles 3 and 4.
//  4. cp_req every cycle, spi pending, STARVE_MAX=4 -> spi granted immediately after 4th cp grant; counter back to 0.
//  5. Two cp_req on consecutive cycles while FSM busy with spi -> second dropped, cp_overrun=1 stays set until reset.
//  6. Assert reset during WAIT of a read -> no spi_done ever; all outputs 0 the following cycle; next req serviced normally.

Source files
------------

// File: rtl/cmem_pkg.sv
// Shared types and constants for the cmem port arbiter and its request buffers.
package cmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam logic SIDE_CP  = 1'b0;
  localparam logic SIDE_SPI = 1'b1;

  localparam logic [3:0] REG_VERSION  = 4'd10;
  localparam logic [3:0] REG_CONFIG   = 4'd11;
  localparam logic [3:0] REG_R_EVENTS = 4'd12;
  localparam logic [3:0] REG_R_ENABLE = 4'd13;
  localparam logic [3:0] REG_A_EVENTS = 4'd14;
  localparam logic [3:0] REG_A_ENABLE = 4'd15;

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [3:0] wdata;
  } req_t;

endpackage

// File: rtl/cmem_req_buf.sv
// One-deep capture buffer for a single requester's access pulse.
module cmem_req_buf
  import cmem_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       req_i,
  input  logic       we_i,
  input  logic [3:0] addr_i,
  input  logic [3:0] wdata_i,
  input  logic       free_i,
  output logic       valid_o,
  output req_t       req_o,
  output logic       overrun_o
);

  logic valid_q, valid_d;
  logic overrun_q, overrun_d;
  req_t data_q, data_d;
  logic accept;

  // A slot being freed this cycle may be refilled in the same cycle.
  always_comb begin
    accept    = req_i && (!valid_q || free_i);
    valid_d   = valid_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = '{we: we_i, addr: addr_i, wdata: wdata_i};
    end else if (free_i) begin
      valid_d = 1'b0;
    end
    if (req_i && !accept) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      data_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      data_q    <= data_d;
    end
  end

  assign valid_o   = valid_q;
  assign req_o     = data_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/cmem_access_arbiter.sv
// Serialises clockport and SPI accesses onto the single cmem register-file port.
module cmem_access_arbiter
  import cmem_pkg::*;
#(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       clk200_i,
  input  logic       reset_i,
  input  logic       cp_req_i,
  input  logic       cp_we_i,
  input  logic [3:0] cp_addr_i,
  input  logic [3:0] cp_wdata_i,
  output logic       cp_busy_o,
  output logic       cp_done_o,
  output logic [3:0] cp_rdata_o,
  output logic       cp_overrun_o,
  input  logic       spi_req_i,
  input  logic       spi_we_i,
  input  logic [3:0] spi_addr_i,
  input  logic [3:0] spi_wdata_i,
  output logic       spi_busy_o,
  output logic       spi_done_o,
  output logic [3:0] spi_rdata_o,
  output logic       spi_overrun_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic [3:0] mem_address_o,
  output logic [3:0] mem_wdata_o,
  output logic       mem_side_o,
  input  logic [3:0] mem_rdata_i
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [1:0] WAIT_INIT  = 2'(RD_LAT - 1);

  arb_state_e state_q, state_d;
  logic [1:0] wait_q, wait_d;
  logic [3:0] starve_q, starve_d;
  logic       read_q, read_d, write_q, write_d, side_q, side_d;
  logic [3:0] addr_q, addr_d, wdata_q, wdata_d;
  logic       cp_done_q, cp_done_d, spi_done_q, spi_done_d;
  logic [3:0] cp_rdata_q, cp_rdata_d, spi_rdata_q, spi_rdata_d;

  logic cp_valid, spi_valid, cp_free, spi_free;
  logic cp_elig, spi_elig, can_grant, grant, pick_spi;
  req_t cp_buf, spi_buf, win;

  cmem_req_buf u_cp_buf (
    .clk_i(clk200_i), .reset_i(reset_i), .req_i(cp_req_i), .we_i(cp_we_i),
    .addr_i(cp_addr_i), .wdata_i(cp_wdata_i), .free_i(cp_free),
    .valid_o(cp_valid), .req_o(cp_buf), .overrun_o(cp_overrun_o)
  );

  cmem_req_buf u_spi_buf (
    .clk_i(clk200_i), .reset_i(reset_i), .req_i(spi_req_i), .we_i(spi_we_i),
    .addr_i(spi_addr_i), .wdata_i(spi_wdata_i), .free_i(spi_free),
    .valid_o(spi_valid), .req_o(spi_buf), .overrun_o(spi_overrun_o)
  );

  // A write in ISSUE may chain straight into the next grant; the issuing buffer is not eligible.
  always_comb begin
    cp_free   = (state_q == ISSUE) && (side_q == SIDE_CP);
    spi_free  = (state_q == ISSUE) && (side_q == SIDE_SPI);
    cp_elig   = cp_valid && !cp_free;
    spi_elig  = spi_valid && !spi_free;
    can_grant = (state_q == IDLE) || ((state_q == ISSUE) && write_q);
    grant     = can_grant && (cp_elig || spi_elig);
    pick_spi  = spi_elig && (!cp_elig || (starve_q == STARVE_LIM));
    win       = pick_spi ? spi_buf : cp_buf;
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    read_d      = 1'b0;
    write_d     = 1'b0;
    side_d      = side_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cp_done_d   = 1'b0;
    spi_done_d  = 1'b0;
    cp_rdata_d  = cp_rdata_q;
    spi_rdata_d = spi_rdata_q;
    starve_d    = starve_q;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      ISSUE: begin
        if (write_q) begin
          cp_done_d  = (side_q == SIDE_CP);
          spi_done_d = (side_q == SIDE_SPI);
          state_d    = IDLE;
        end else begin
          wait_d  = WAIT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_q == 2'd0) begin
          state_d = IDLE;
          if (side_q == SIDE_SPI) begin
            spi_done_d  = 1'b1;
            spi_rdata_d = mem_rdata_i;
          end else begin
            cp_done_d  = 1'b1;
            cp_rdata_d = mem_rdata_i;
          end
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      state_d = ISSUE;
      read_d  = !win.we;
      write_d = win.we;
      addr_d  = win.addr;
      wdata_d = win.wdata;
      side_d  = pick_spi ? SIDE_SPI : SIDE_CP;
    end

    // Only cp grants made while spi is genuinely waiting count towards starvation.
    if (!spi_elig || (grant && pick_spi)) begin
      starve_d = 4'd0;
    end else if (grant && (starve_q < STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk200_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      starve_q    <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      side_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cp_done_q   <= 1'b0;
      spi_done_q  <= 1'b0;
      cp_rdata_q  <= '0;
      spi_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      read_q      <= read_d;
      write_q     <= write_d;
      side_q      <= side_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cp_done_q   <= cp_done_d;
      spi_done_q  <= spi_done_d;
      cp_rdata_q  <= cp_rdata_d;
      spi_rdata_q <= spi_rdata_d;
    end
  end

  assign cp_busy_o     = cp_valid;
  assign spi_busy_o    = spi_valid;
  assign cp_done_o     = cp_done_q;
  assign spi_done_o    = spi_done_q;
  assign cp_rdata_o    = cp_rdata_q;
  assign spi_rdata_o   = spi_rdata_q;
  assign mem_read_o    = read_q;
  assign mem_write_o   = write_q;
  assign mem_address_o = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign mem_side_o    = side_q;

endmodule
